// File: rtl/freq_ratio_meter.sv
// Measures period and high time of a slow clock sampled as data in the clk domain.
// Optional 2-flop input synchronizer is enabled with `define FREQ_METER_SYNC2_EN.
module freq_ratio_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             lost
);

  typedef enum logic [1:0] {ARM_LOW, ARM_EDGE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic samp;

`ifdef FREQ_METER_SYNC2_EN
  localparam logic [1:0] PIPE_DEPTH = 2'd3;

  logic sync_a_reg;
  logic sync_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_reg <= 1'b0;
      sync_b_reg <= 1'b0;
    end else begin
      sync_a_reg <= sig_in;
      sync_b_reg <= sync_a_reg;
    end
  end

  assign samp = sync_b_reg;
`else
  localparam logic [1:0] PIPE_DEPTH = 2'd1;

  assign samp = sig_in;
`endif

  logic             s1_reg;
  logic             s_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] hcnt_reg;
  logic [1:0]       fill_reg;
  state_t           state_reg;
  logic             rise;
  logic             primed;

  assign rise   = s1_reg & ~s_prev_reg;
  // s1 holds reset zeros until the input pipeline has refilled with real samples;
  // arming on those zeros would let a high input at reset release look like an edge.
  assign primed = (fill_reg == PIPE_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg     <= 1'b0;
      s_prev_reg <= 1'b0;
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      fill_reg   <= 2'd0;
      state_reg  <= ARM_LOW;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      lost       <= 1'b0;
    end else begin
      s1_reg     <= samp;
      s_prev_reg <= s1_reg;
      meas_valid <= 1'b0;
      if (!primed) begin
        fill_reg <= fill_reg + 2'd1;
      end
      case (state_reg)
        ARM_LOW: begin
          if (primed && !s1_reg) begin
            state_reg <= ARM_EDGE;
          end
        end
        ARM_EDGE: begin
          if (rise) begin
            state_reg <= MEASURE;
            cnt_reg   <= CNT_ONE;
            hcnt_reg  <= CNT_ONE;
          end
        end
        MEASURE: begin
          // An edge landing on the timeout cycle is still a valid period.
          if (rise) begin
            period_out <= cnt_reg;
            high_out   <= hcnt_reg;
            meas_valid <= 1'b1;
            lost       <= 1'b0;
            cnt_reg    <= CNT_ONE;
            hcnt_reg   <= CNT_ONE;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            lost      <= 1'b1;
            state_reg <= ARM_LOW;
          end else begin
            cnt_reg  <= cnt_reg + CNT_ONE;
            hcnt_reg <= hcnt_reg + {{(CNT_W-1){1'b0}}, s1_reg};
          end
        end
        default: begin
          state_reg <= ARM_LOW;
        end
      endcase
    end
  end

endmodule
